// File: rtl/hsv_rgb_pwm_pkg.sv
// hsv_pkg: shared constants, FSM state type and helpers for the HSV -> RGB PWM
// block.
//   HUE_MOD..HSV_W : colour-space and datapath widths
//   state_e        : conversion FSM states
//   sector_t       : hue sector index 0..5
//   sat8()         : clamps a divider quotient to 8 bits
package hsv_pkg;

   localparam int HUE_MOD  = 360;
   localparam int SV_MAX   = 100;
   localparam int DUTY_MAX = 255;
   localparam int PWM_TOP  = 254;
   localparam int DUTY_W   = 8;
   localparam int HSV_W    = 9;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SECTOR    = 3'd1,
      ST_DIV_VMAX  = 3'd2,
      ST_DIV_VMIN  = 3'd3,
      ST_DIV_DELTA = 3'd4,
      ST_STORE     = 3'd5
   } state_e;

   typedef logic [2:0] sector_t;

   // All quotients in this design are <= 255 by construction; the clamp only
   // keeps an out-of-range result from wrapping.
   function automatic logic [DUTY_W-1:0] sat8(input logic [15:0] x);
      return (x[15:8] != 8'd0) ? 8'hFF : x[7:0];
   endfunction

endpackage

// File: rtl/hsv_rgb_pwm_if.sv
// hsv_rgb_pwm_if: colour input and PWM/debug output bundle.
//   Hue/Saturation/Value : HSV request, sampled only at a PWM period start
//   led_r/g/b            : PWM outputs
//   duty_r/g/b           : duties active in the current period
//   busy                 : conversion FSM not idle
//   period_start         : one-cycle pulse in the cycle the PWM count wraps
//   state_dbg            : raw FSM state
// There is no valid/ready pair: the block samples the HSV inputs at every
// period start while idle, so the producer simply holds its current colour.
interface hsv_rgb_pwm_if;
   import hsv_pkg::*;

   logic [HSV_W-1:0]  Hue;
   logic [HSV_W-1:0]  Saturation;
   logic [HSV_W-1:0]  Value;
   logic              led_r;
   logic              led_g;
   logic              led_b;
   logic [DUTY_W-1:0] duty_r;
   logic [DUTY_W-1:0] duty_g;
   logic [DUTY_W-1:0] duty_b;
   logic              busy;
   logic              period_start;
   state_e            state_dbg;

   modport master (
      output Hue, Saturation, Value,
      input  led_r, led_g, led_b, duty_r, duty_g, duty_b, busy, period_start, state_dbg
   );

   modport slave (
      input  Hue, Saturation, Value,
      output led_r, led_g, led_b, duty_r, duty_g, duty_b, busy, period_start, state_dbg
   );

endinterface

// File: rtl/hsv_rgb_pwm_seq_divider.sv
// seq_divider: unsigned restoring divider, 16-bit dividend / 8-bit divisor,
// one quotient bit per cycle.
//   start_i    : load operands and begin (takes priority over a running divide)
//   dividend_i : 16-bit dividend
//   divisor_i  : 8-bit divisor, must be non-zero
//   done_o     : one-cycle pulse, quotient_o valid in that cycle
//   quotient_o : 16-bit quotient
// done_o arrives 17 cycles after the start_i cycle.
module seq_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [15:0] dividend_i,
   input  logic [7:0]  divisor_i,
   output logic        done_o,
   output logic [15:0] quotient_o
);

   logic [15:0] quo_q, quo_d;
   logic [7:0]  rem_q, rem_d;
   logic [7:0]  dvs_q, dvs_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        run_q, run_d;
   logic        done_q, done_d;
   logic [8:0]  shifted;
   logic [9:0]  trial;

   always_comb begin
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      done_d  = 1'b0;
      // Quotient register doubles as the dividend shift register.
      shifted = {rem_q, quo_q[15]};
      trial   = {1'b0, shifted} - {2'b00, dvs_q};
      if (start_i) begin
         quo_d = dividend_i;
         rem_d = 8'd0;
         dvs_d = divisor_i;
         cnt_d = 5'd16;
         run_d = 1'b1;
      end else if (run_q) begin
         if (!trial[9]) begin
            rem_d = trial[7:0];
            quo_d = {quo_q[14:0], 1'b1};
         end else begin
            rem_d = shifted[7:0];
            quo_d = {quo_q[14:0], 1'b0};
         end
         cnt_d = cnt_q - 5'd1;
         if (cnt_q == 5'd1) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign done_o     = done_q;
   assign quotient_o = quo_q;

endmodule

// File: rtl/hsv_rgb_pwm.sv
// hsv_rgb_pwm: HSV -> RGB conversion plus three-channel PWM for the board LED.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : hsv_rgb_pwm_if.slave (HSV in, LEDs / duties / status out)
// Inputs are latched at a period start, converted into shadow duties by a
// multi-cycle FSM sharing one serial divider, and the shadow duties become
// active at the following period start, so a period never mixes two colours.
module hsv_rgb_pwm
   import hsv_pkg::*;
#(
   parameter int unsigned PRESC_DIV    = 39,
   parameter bit          COMMON_ANODE = 1'b0
) (
   input logic          clk,
   input logic          reset,
   hsv_rgb_pwm_if.slave bus
);

   // A conversion (~58 cycles) must always finish inside one PWM period.
   if (PRESC_DIV < 1 || PRESC_DIV > 65535 || PRESC_DIV * 255 < 64) begin : g_presc_chk
      $error("hsv_rgb_pwm: PRESC_DIV out of range");
   end

   localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

   // ---------------- PWM timebase ----------------
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          tick, wrap;

   assign tick    = (presc_q == PW'(PRESC_DIV - 1));
   assign wrap    = tick && (cnt_q == 8'(PWM_TOP));
   assign presc_d = tick ? '0 : presc_q + 1'b1;
   assign cnt_d   = wrap ? 8'd0 : (tick ? cnt_q + 8'd1 : cnt_q);

   // ---------------- conversion FSM ----------------
   state_e            state_q, state_d;
   logic [HSV_W-1:0]  h_q, h_d;
   logic [6:0]        s_q, s_d;
   logic [6:0]        v_q, v_d;
   sector_t           sector_q, sector_d;
   logic [DUTY_W-1:0] vmax_q, vmax_d, vmin_q, vmin_d, delta_q, delta_d;
   logic [DUTY_W-1:0] sh_r_q, sh_r_d, sh_g_q, sh_g_d, sh_b_q, sh_b_d;
   logic [DUTY_W-1:0] duty_r_q, duty_g_q, duty_b_q;
   logic [DUTY_W-1:0] q8, rise, fall;
   logic              div_start, div_done;
   logic [15:0]       div_dividend, div_quotient;
   logic [7:0]        div_divisor;

   seq_divider u_div (
      .clk        (clk),
      .reset      (reset),
      .start_i    (div_start),
      .dividend_i (div_dividend),
      .divisor_i  (div_divisor),
      .done_o     (div_done),
      .quotient_o (div_quotient)
   );

   always_comb begin
      state_d      = state_q;
      h_d          = h_q;
      s_d          = s_q;
      v_d          = v_q;
      sector_d     = sector_q;
      vmax_d       = vmax_q;
      vmin_d       = vmin_q;
      delta_d      = delta_q;
      sh_r_d       = sh_r_q;
      sh_g_d       = sh_g_q;
      sh_b_d       = sh_b_q;
      div_start    = 1'b0;
      div_dividend = 16'd0;
      div_divisor  = 8'd1;
      q8           = sat8(div_quotient);
      rise         = vmin_q + delta_q;
      fall         = vmax_q - delta_q;
      case (state_q)
         ST_IDLE: begin
            if (wrap) begin
               h_d      = (bus.Hue >= 9'(HUE_MOD)) ? bus.Hue - 9'(HUE_MOD) : bus.Hue;
               s_d      = (bus.Saturation > 9'(SV_MAX)) ? 7'(SV_MAX) : bus.Saturation[6:0];
               v_d      = (bus.Value > 9'(SV_MAX)) ? 7'(SV_MAX) : bus.Value[6:0];
               sector_d = '0;
               state_d  = ST_SECTOR;
            end
         end
         ST_SECTOR: begin
            // Repeated subtraction leaves f = H mod 60 in h_q.
            if (h_q >= 9'd60) begin
               h_d      = h_q - 9'd60;
               sector_d = sector_q + 3'd1;
            end else begin
               div_start    = 1'b1;
               div_dividend = 16'(v_q) * 16'(DUTY_MAX);
               div_divisor  = 8'(SV_MAX);
               state_d      = ST_DIV_VMAX;
            end
         end
         ST_DIV_VMAX: begin
            // Each result is consumed in its done cycle to chain the next divide.
            if (div_done) begin
               vmax_d       = q8;
               div_start    = 1'b1;
               div_dividend = 16'(q8) * 16'(7'(SV_MAX) - s_q);
               div_divisor  = 8'(SV_MAX);
               state_d      = ST_DIV_VMIN;
            end
         end
         ST_DIV_VMIN: begin
            if (div_done) begin
               vmin_d       = q8;
               div_start    = 1'b1;
               div_dividend = 16'(vmax_q - q8) * 16'(h_q[5:0]);
               div_divisor  = 8'd60;
               state_d      = ST_DIV_DELTA;
            end
         end
         ST_DIV_DELTA: begin
            if (div_done) begin
               delta_d = q8;
               state_d = ST_STORE;
            end
         end
         ST_STORE: begin
            case (sector_q)
               3'd0:    {sh_r_d, sh_g_d, sh_b_d} = {vmax_q, rise,   vmin_q};
               3'd1:    {sh_r_d, sh_g_d, sh_b_d} = {fall,   vmax_q, vmin_q};
               3'd2:    {sh_r_d, sh_g_d, sh_b_d} = {vmin_q, vmax_q, rise};
               3'd3:    {sh_r_d, sh_g_d, sh_b_d} = {vmin_q, fall,   vmax_q};
               3'd4:    {sh_r_d, sh_g_d, sh_b_d} = {rise,   vmin_q, vmax_q};
               default: {sh_r_d, sh_g_d, sh_b_d} = {vmax_q, vmin_q, fall};
            endcase
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q  <= '0;
         cnt_q    <= '0;
         state_q  <= ST_IDLE;
         h_q      <= '0;
         s_q      <= '0;
         v_q      <= '0;
         sector_q <= '0;
         vmax_q   <= '0;
         vmin_q   <= '0;
         delta_q  <= '0;
         sh_r_q   <= '0;
         sh_g_q   <= '0;
         sh_b_q   <= '0;
         duty_r_q <= '0;
         duty_g_q <= '0;
         duty_b_q <= '0;
      end else begin
         presc_q  <= presc_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         h_q      <= h_d;
         s_q      <= s_d;
         v_q      <= v_d;
         sector_q <= sector_d;
         vmax_q   <= vmax_d;
         vmin_q   <= vmin_d;
         delta_q  <= delta_d;
         sh_r_q   <= sh_r_d;
         sh_g_q   <= sh_g_d;
         sh_b_q   <= sh_b_d;
         if (wrap) begin
            duty_r_q <= sh_r_q;
            duty_g_q <= sh_g_q;
            duty_b_q <= sh_b_q;
         end
      end
   end

   // Count runs 0..254, so duty 255 is always on and duty 0 always off.
   assign bus.led_r        = (cnt_q < duty_r_q) ^ COMMON_ANODE;
   assign bus.led_g        = (cnt_q < duty_g_q) ^ COMMON_ANODE;
   assign bus.led_b        = (cnt_q < duty_b_q) ^ COMMON_ANODE;
   assign bus.duty_r       = duty_r_q;
   assign bus.duty_g       = duty_g_q;
   assign bus.duty_b       = duty_b_q;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.period_start = wrap;
   assign bus.state_dbg    = state_q;

endmodule

// File: doc/hsv_rgb_pwm.md
Name: hsv_rgb_pwm

Overview:
Consumer of the Hue/Saturation/Value triple produced by the button-driven colour controller. It converts HSV to 8-bit R/G/B duty values using a multi-cycle FSM with a shared serial divider. It then drives three PWM outputs for the board RGB LED. New colours are sampled at every PWM period start and become visible one period later, so no duty value is ever torn mid-period.

Parameters:
PRESC_DIV, 39, clk cycles per PWM tick (10 MHz clk -> ~1 kHz PWM); legal range 1..65535.
COMMON_ANODE, 0, 1 = invert led_r/led_g/led_b.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
Hue  in  9  0..359 nominal; 360..511 tolerated
Saturation  in  9  0..100 nominal
Value  in  9  0..100 nominal
led_r, led_g, led_b  out  1 each  PWM outputs
duty_r, duty_g, duty_b  out  8 each  active duty (debug/verification)
busy  out  1  conversion FSM not IDLE
period_start  out  1  one-cycle pulse when the PWM counter returns to 0

Behaviour:
- Reset: duty_* = 0, shadow duties = 0, prescaler = 0, PWM count = 0, FSM = IDLE, busy = 0, period_start = 0, led_* = COMMON_ANODE.
- Reset asserted mid-conversion aborts it; nothing partial reaches the shadow or active duties.
- Prescaler counts 0..PRESC_DIV-1. A tick occurs on wrap.
- PWM count advances on each tick, 0..254, and wraps to 0 (period = 255 ticks).
- period_start = 1 in the cycle the count wraps 254->0.
- led_x = (count < duty_x), XOR COMMON_ANODE. Duty 0 gives always off; duty 255 gives always on.
- At period_start, same cycle:
  - shadow duties -> duty_*.
  - If FSM is IDLE, the inputs are latched and the FSM leaves IDLE.
- Input conditioning at latch:
  - H' = H-360 if H >= 360, else H.
  - S' = min(S,100); V' = min(V,100).
- Arithmetic (all unsigned, every division floors):
  - sector = H'/60; f = H' - 60*sector.
  - vmax = V'*255/100.
  - vmin = vmax*(100-S')/100.
  - d = (vmax-vmin)*f/60.
  - rise = vmin+d; fall = vmax-d.
- Sector mapping (R,G,B):
  - 0: (vmax, rise, vmin)
  - 1: (fall, vmax, vmin)
  - 2: (vmin, vmax, rise)
  - 3: (vmin, fall, vmax)
  - 4: (rise, vmin, vmax)
  - 5: (vmax, vmin, fall)
- FSM states: IDLE -> SECTOR (compare-subtract 60, <=6 cycles) -> DIV_VMAX -> DIV_VMIN -> DIV_DELTA -> STORE -> IDLE.
  - Each DIV_* state starts seq_divider and waits for its done signal.
  - STORE writes the shadow duties.
  - Total conversion <= 64 cycles; busy is high from the latch cycle through STORE.
- Constraint PRESC_DIV*255 >= 64 guarantees IDLE at every period_start. Elaboration fails otherwise.
- Latency: input change -> visible duty = up to 2 PWM periods. Latched inputs are ignored until the next period_start.

Decomposition:
- Package hsv_pkg:
  - HUE_MOD=360, SV_MAX=100, DUTY_MAX=255, PWM_TOP=254, DUTY_W=8, HSV_W=9.
  - FSM state enum.
  - Sector type (3 bits).
- Sub-module seq_divider:
  - Unsigned restoring divider, 16-bit dividend / 8-bit divisor.
  - 1 bit per cycle; start/done handshake.
  - Reset clears done and quotient.
  - Shared by all three divisions.

Test Plan:
- H=0,S=100,V=100, PRESC_DIV=1 -> after 2 period_starts duty=(255,0,0); led_r constantly 1, led_g/led_b constantly 0.
- H=120,S=80,V=80 (controller reset/state-0 colour) -> duty=(40,204,40); led_g high for 204 of 255 ticks.
- H=90,S=100,V=100 -> (128,255,0). H=359 -> (255,0,5). H=360 -> (255,0,0), identical to H=0.
- S=0,V=50, any H -> (127,127,127). S=150,V=200 clamped -> same result as S=100,V=100.
- Change H from 0 to 240 mid-period -> duty_* unchanged until the second period_start, then (0,0,255); never a mixed value.
- Assert reset while busy=1 -> next cycle busy=0, duty_*=0, leds = COMMON_ANODE. After release, first conversion completes correctly. Repeat with COMMON_ANODE=1 to confirm inversion.
